// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared types and constants for the parametrised UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // One FIFO entry carries {perr, ferr, data}.
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive-side FIFO head, handshake and status signals
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_data;
    logic                 o_perr;
    logic                 o_ferr;
    logic                 o_valid;
    logic                 i_accept;
    logic                 o_overrun;
    logic                 o_busy;

    modport master (
        output o_data, o_perr, o_ferr, o_valid, o_overrun, o_busy,
        input  i_accept
    );

    modport slave (
        input  o_data, o_perr, o_ferr, o_valid, o_overrun, o_busy,
        output i_accept
    );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// rtl/uart_rx_fifo_sync_fifo.sv - show-ahead synchronous FIFO with drop-on-full reporting
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full || do_pop);
        drop_o   = push_i && full && !do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        head_o   = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            end
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with majority-vote sampling, error flags and frame FIFO
module uart_rx_fifo #(
    parameter int SAMPLE    = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_rx,
    uart_rx_fifo_if.master rx_if
);
    import uart_pkg::*;

    localparam int CW = $clog2(SAMPLE);
    localparam int EW = entry_width(DATA_BITS);
    localparam int IW = 4;
    localparam logic [CW-1:0] CNT_V0   = CW'(SAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(SAMPLE / 2);
    localparam logic [CW-1:0] CNT_MID  = CW'(SAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE - 1);

    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 overrun_q;
    logic                 vote, at_mid, at_last, fall, push;
    logic [EW-1:0]        push_data, head;
    logic                 empty, drop;

    always_comb begin
        vote      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
        at_mid    = (cnt_q == CNT_MID);
        at_last   = (cnt_q == CNT_LAST);
        fall      = rx_prev_q & ~rx_s_q;
        state_d   = state_q;
        cnt_d     = at_last ? '0 : cnt_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        s0_d      = (cnt_q == CNT_V0) ? rx_s_q : s0_q;
        s1_d      = (cnt_q == CNT_V1) ? rx_s_q : s1_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = ST_START;
                    bit_d   = '0;
                    shift_d = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (at_mid && vote) begin
                    state_d = ST_IDLE;
                end else if (at_last) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (at_mid) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                end
                if (at_last) begin
                    if (bit_q == IW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_d = bit_q + IW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (at_mid) begin
                    perr_d = ((^shift_q) ^ vote) != logic'(PARITY == PAR_ODD);
                end
                if (at_last) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_mid) begin
                    ferr_d = ferr_q | ~vote;
                    // Leave half a bit early so the next start edge is never missed.
                    if (bit_q == IW'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (at_last) begin
                    bit_d = bit_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        push_data = {perr_d, ferr_d, shift_q};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            overrun_q <= drop;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (i_clk),
        .rst         (i_rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (rx_if.i_accept),
        .head_o      (head),
        .empty_o     (empty),
        .drop_o      (drop)
    );

    assign rx_if.o_data    = head[DATA_BITS-1:0];
    assign rx_if.o_ferr    = head[DATA_BITS];
    assign rx_if.o_perr    = head[DATA_BITS+1];
    assign rx_if.o_valid   = ~empty;
    assign rx_if.o_overrun = overrun_q;
    assign rx_if.o_busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for an 8N1 and an 8E1 receiver instance
module tb_uart_rx_fifo;
    localparam int SAMPLE = 16;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    logic rx_a, rx_b;
    int   checks = 0;
    int   errors = 0;
    int   mode_a = 0, mode_b = 0;
    int   ovr_a = 0, ovr_b = 0, exp_ovr_a = 0;
    entry_t exp_a[$];
    entry_t exp_b[$];

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8)) ifa ();
    uart_rx_fifo_if #(.DATA_BITS(8)) ifb ();

    uart_rx_fifo #(.SAMPLE(SAMPLE), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(DEPTH)) dut_a (
        .i_clk (clk), .i_rst (rst), .i_rx (rx_a), .rx_if (ifa)
    );
    uart_rx_fifo #(.SAMPLE(SAMPLE), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(DEPTH)) dut_b (
        .i_clk (clk), .i_rst (rst), .i_rx (rx_b), .rx_if (ifb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: choose accept each cycle, and compare whatever the DUT hands over.
    initial begin
        ifa.i_accept = 1'b0;
        forever begin
            @(negedge clk);
            ifa.i_accept = (mode_a == 0) ? 1'($urandom_range(0, 1)) : (mode_a == 2);
            if (ifa.o_overrun) ovr_a++;
            if (ifa.o_valid && ifa.i_accept) begin
                check("a_pop_expected", 32'(exp_a.size() > 0), 1);
                if (exp_a.size() > 0) begin
                    entry_t e;
                    e = exp_a.pop_front();
                    check("a_entry", {ifa.o_perr, ifa.o_ferr, ifa.o_data}, e);
                end
            end
        end
    end

    initial begin
        ifb.i_accept = 1'b0;
        forever begin
            @(negedge clk);
            ifb.i_accept = (mode_b == 0) ? 1'($urandom_range(0, 1)) : (mode_b == 2);
            if (ifb.o_overrun) ovr_b++;
            if (ifb.o_valid && ifb.i_accept) begin
                check("b_pop_expected", 32'(exp_b.size() > 0), 1);
                if (exp_b.size() > 0) begin
                    entry_t e;
                    e = exp_b.pop_front();
                    check("b_entry", {ifb.o_perr, ifb.o_ferr, ifb.o_data}, e);
                end
            end
        end
    end

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input bit par_en,
                              input logic par_bit, input logic stop_bit);
        logic [10:0] bits;
        int          n;
        if (par_en) begin
            bits = {stop_bit, par_bit, data, 1'b0};
            n    = 11;
        end else begin
            bits = {1'b1, stop_bit, data, 1'b0};
            n    = 10;
        end
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            repeat (SAMPLE) @(negedge clk);
        end
        drive(sel, 1'b1);
    endtask

    // 8N1 model: with no consumer the FIFO fills to DEPTH and further frames are lost.
    task automatic send_a(input logic [7:0] data, input logic stop_bit);
        entry_t e;
        e.perr = 1'b0;
        e.ferr = ~stop_bit;
        e.data = data;
        if (mode_a == 1 && exp_a.size() >= DEPTH) exp_ovr_a++;
        else exp_a.push_back(e);
        send_frame(0, data, 0, 1'b0, stop_bit);
    endtask

    // 8E1 model: parity is correct when the count of ones over data and parity bit is even.
    task automatic send_b(input logic [7:0] data, input logic flip);
        entry_t e;
        int     ones;
        logic   pbit;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += data[i];
        pbit   = logic'(ones % 2) ^ flip;
        e.perr = ((ones + pbit) % 2) != 0;
        e.ferr = 1'b0;
        e.data = data;
        exp_b.push_back(e);
        send_frame(1, data, 1, pbit, 1'b1);
    endtask

    task automatic drain(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (SAMPLE) @(negedge clk);
        if (sel == 0) begin
            check("drain_a", exp_a.size(), 0);
            check("idle_valid_a", ifa.o_valid, 0);
        end else begin
            check("drain_b", exp_b.size(), 0);
            check("idle_valid_b", ifb.o_valid, 0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_a"}, ifa.o_data, 0);
        check({tag, "_perr_a"}, ifa.o_perr, 0);
        check({tag, "_ferr_a"}, ifa.o_ferr, 0);
        check({tag, "_valid_a"}, ifa.o_valid, 0);
        check({tag, "_overrun_a"}, ifa.o_overrun, 0);
        check({tag, "_busy_a"}, ifa.o_busy, 0);
        check({tag, "_valid_b"}, ifb.o_valid, 0);
        check({tag, "_busy_b"}, ifb.o_busy, 0);
    endtask

    initial begin
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_zero("post_reset");

        send_a(8'h11, 1'b1);
        send_a(8'hAA, 1'b1);
        drain(0);

        send_b(8'hD6, 1'b1);
        send_b(8'hD6, 1'b0);
        drain(1);

        send_a(8'hE2, 1'b0);
        repeat (2 * SAMPLE) @(negedge clk);
        send_a(8'h11, 1'b1);
        drain(0);

        rx_a = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch_busy_high", ifa.o_busy, 1);
        rx_a = 1'b1;
        repeat (13) @(negedge clk);
        check("glitch_busy_low", ifa.o_busy, 0);
        repeat (2 * SAMPLE) @(negedge clk);
        check("glitch_no_push", ifa.o_valid, 0);

        mode_a = 1;
        ovr_a  = 0;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        check("overrun_pulses", ovr_a, exp_ovr_a);
        check("full_valid", ifa.o_valid, 1);
        check("full_head", ifa.o_data, exp_a[0].data);
        mode_a = 2;
        drain(0);
        check("overrun_after_drain", ovr_a, exp_ovr_a);
        mode_a = 0;

        fork
            send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
            begin
                repeat (SAMPLE * 4 + 6) @(negedge clk);
                check("pre_reset_busy", ifa.o_busy, 1);
                rst = 1'b1;
                @(negedge clk);
                check_zero("mid_reset");
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        send_a(8'h5A, 1'b1);
        drain(0);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic       stop;
            int         gap;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 9) != 0);
            gap  = stop ? $urandom_range(0, 8) : SAMPLE + $urandom_range(0, 8);
            send_a(d, stop);
            repeat (gap) @(negedge clk);
            send_b(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        drain(0);
        drain(1);
        check("overrun_total_a", ovr_a, exp_ovr_a);
        check("overrun_total_b", ovr_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
